// File: rtl/cordic_seq_pkg.sv
// Shared definitions for the CORDIC LUT sequencer.
//   state_t      : sequencer FSM states (idle, load, iterate, done)
//   CORDIC_W     : default ROM word / angle width
//   CORDIC_N     : default ROM address width
//   CORDIC_ITER  : default iterations per operation (1..2**CORDIC_N)
package cordic_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned CORDIC_W    = 32;
    localparam int unsigned CORDIC_N    = 3;
    localparam int unsigned CORDIC_ITER = 8;

endpackage

// File: rtl/cordic_lut_sequencer_if.sv
// Bundle between the CORDIC sequencer, its controller and the LUT ROM/datapath.
//   beg_fsm, ack         : start request / result-taken handshake (controller -> sequencer)
//   busy, ready          : status back to the controller
//   rom_addr, rom_data   : LUT ROM address out, combinational ROM word back
//   lut_angle, iter_cnt  : angle word and shift amount for the datapath
//   load_init, enab_iter : datapath load and micro-rotation enables
// The slave modport is the sequencer; master is everything around it.
interface cordic_lut_sequencer_if #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 3
);
    logic         beg_fsm;
    logic         ack;
    logic         busy;
    logic         ready;
    logic [N-1:0] rom_addr;
    logic [W-1:0] rom_data;
    logic [W-1:0] lut_angle;
    logic [N-1:0] iter_cnt;
    logic         load_init;
    logic         enab_iter;

    modport slave (
        input  beg_fsm, ack, rom_data,
        output busy, ready, rom_addr, lut_angle, iter_cnt, load_init, enab_iter
    );

    modport master (
        output beg_fsm, ack, rom_data,
        input  busy, ready, rom_addr, lut_angle, iter_cnt, load_init, enab_iter
    );
endinterface

// File: rtl/cordic_lut_sequencer.sv
// Sequences one CORDIC rotation: walks the angle LUT ROM, registers each word
// for the datapath and drives the load / iteration enables.
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset
//   bus : slave side of cordic_lut_sequencer_if (handshake, ROM, datapath controls)
// Status and enables are decoded from the state register only.
module cordic_lut_sequencer
    import cordic_seq_pkg::*;
#(
    parameter int unsigned W    = CORDIC_W,
    parameter int unsigned N    = CORDIC_N,
    parameter int unsigned ITER = CORDIC_ITER
) (
    input  logic                    clk,
    input  logic                    rst,
    cordic_lut_sequencer_if.slave   bus
);

    localparam logic [N-1:0] ITER_LAST = N'(ITER - 1);

    state_t       state;
    logic [N-1:0] rom_addr;
    logic [N-1:0] iter_cnt;
    logic [W-1:0] lut_angle;
    logic         last_iter;

    assign last_iter = (iter_cnt == ITER_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rom_addr  <= '0;
            iter_cnt  <= '0;
            lut_angle <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.beg_fsm) begin
                        state    <= ST_LOAD;
                        rom_addr <= '0;
                        iter_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    lut_angle <= bus.rom_data;
                    rom_addr  <= rom_addr + N'(1);
                    state     <= ST_ITER;
                end
                ST_ITER: begin
                    rom_addr <= rom_addr + N'(1);
                    if (last_iter) begin
                        // The word fetched on the final iteration lies past the
                        // last entry used; keep the final angle visible in DONE.
                        state <= ST_DONE;
                    end else begin
                        lut_angle <= bus.rom_data;
                        iter_cnt  <= iter_cnt + N'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.ack) begin
                        state    <= ST_IDLE;
                        iter_cnt <= '0;
                        rom_addr <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rom_addr  = rom_addr;
    assign bus.iter_cnt  = iter_cnt;
    assign bus.lut_angle = lut_angle;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.load_init = (state == ST_LOAD);
    assign bus.enab_iter = (state == ST_ITER);
    assign bus.ready     = (state == ST_DONE);

endmodule
